// File: rtl/tva_pkg.sv
// Shared types and sizing helpers for the token sequencer and its watchdog.
package tva_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      ERR
   } tok_seq_state_t;

   function automatic int wdog_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

   // A single-token sequence still needs a 1-bit index.
   function automatic int idx_w(input int seq_len);
      return (seq_len > 1) ? $clog2(seq_len) : 1;
   endfunction

   localparam int TOK_WDOG_W = wdog_w(64);
   localparam int TOK_IDX_W  = idx_w(8);

endpackage

// File: rtl/token_sequencer_tok_watchdog.sv
// Clear/enable stall counter; expired_o flags that the current strobe-less
// WAIT cycle is the last one allowed.
module tok_watchdog
   import tva_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = wdog_w(TIMEOUT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/token_sequencer.sv
// Feeds a latched activation matrix to a per-token engine one row at a time,
// gathers the results and reports completion or a watchdog abort.
module token_sequencer
   import tva_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SEQ_LEN    = 8,
   parameter int EMB_DIM    = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    start,
   input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0]   x_in,
   output logic                                    done,
   output logic                                    out_valid,
   output logic                                    err,
   output logic                                    busy,
   output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0]   y_out,
   output logic                                    eng_start,
   output logic                                    eng_valid_in,
   output logic [DATA_WIDTH*EMB_DIM-1:0]           eng_x,
   input  logic                                    eng_valid_out,
   input  logic [DATA_WIDTH*EMB_DIM-1:0]           eng_y
);

   localparam int TOK_W = DATA_WIDTH * EMB_DIM;
   localparam int MAT_W = TOK_W * SEQ_LEN;
   localparam int IW    = idx_w(SEQ_LEN);

   tok_seq_state_t   state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [MAT_W-1:0] buf_q, buf_d;
   logic [MAT_W-1:0] stg_q, stg_d;
   logic [MAT_W-1:0] y_q, y_d;
   logic [TOK_W-1:0] ex_q, ex_d;
   logic             wd_clr, wd_en, wd_exp;

   tok_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_exp)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      stg_d   = stg_q;
      y_d     = y_q;
      ex_d    = ex_q;
      wd_clr  = 1'b0;
      wd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               buf_d   = x_in;
               idx_d   = '0;
               ex_d    = x_in[TOK_W-1:0];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wd_clr  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            // A strobe on the watchdog's final cycle still wins.
            if (eng_valid_out) begin
               stg_d[int'(idx_q)*TOK_W +: TOK_W] = eng_y;
               if (idx_q == IW'(SEQ_LEN - 1)) begin
                  y_d     = stg_d;
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  ex_d    = buf_q[(int'(idx_q) + 1)*TOK_W +: TOK_W];
                  state_d = ISSUE;
               end
            end else begin
               wd_en = 1'b1;
               if (wd_exp) state_d = ERR;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
         stg_q   <= '0;
         y_q     <= '0;
         ex_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         stg_q   <= stg_d;
         y_q     <= y_d;
         ex_q    <= ex_d;
      end
   end

   assign eng_start    = (state_q == ISSUE);
   assign eng_valid_in = (state_q == ISSUE);
   assign eng_x        = ex_q;
   assign done         = (state_q == DONE) || (state_q == ERR);
   assign out_valid    = (state_q == DONE);
   assign err          = (state_q == ERR);
   assign busy         = (state_q != IDLE);
   assign y_out        = y_q;

endmodule
